// File: rtl/trace_ctrl_pkg.sv
// Shared definitions for the debug trace capture/readout controller.
package trace_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } trace_state_e;

    localparam int TRACE_ADRBITS_DEFAULT  = 12;
    localparam int TRACE_DATABITS_DEFAULT = 16;

    // Buffer depth (2^adrbits) for a given address width.
    function automatic int unsigned trace_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/trace_ctrl_if.sv
// Readout stream and trace RAM port bundle; master is the controller side.
interface trace_ctrl_if #(
    parameter int adrbits  = 12,
    parameter int databits = 16
);
    logic                RdReady;
    logic [databits-1:0] RdData;
    logic                RdValid;
    logic                RdLast;
    logic [adrbits-1:0]  WrAddress;
    logic [databits-1:0] Data;
    logic                WE;
    logic [adrbits-1:0]  RdAddress;
    logic [databits-1:0] Q;

    modport master (
        input  RdReady, Q,
        output RdData, RdValid, RdLast, WrAddress, Data, WE, RdAddress
    );

    modport slave (
        output RdReady, Q,
        input  RdData, RdValid, RdLast, WrAddress, Data, WE, RdAddress
    );
endinterface

// File: rtl/trace_rd_stream.sv
// Streams a frozen circular buffer out of the trace RAM over valid/ready,
// prefetching through the registered read address.
module trace_rd_stream #(
    parameter int adrbits  = 12,
    parameter int databits = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [adrbits-1:0]  start_addr_i,
    input  logic [adrbits:0]    len_i,
    input  logic                active_i,
    input  logic [databits-1:0] q_i,
    input  logic                rd_ready_i,
    output logic [databits-1:0] rd_data_o,
    output logic                rd_valid_o,
    output logic                rd_last_o,
    output logic [adrbits-1:0]  rd_address_o,
    output logic                last_accept_o
);
    localparam logic [adrbits-1:0] PTR_ONE = adrbits'(32'd1);
    localparam logic [adrbits:0]   CNT_ONE = (adrbits + 1)'(32'd1);

    logic [adrbits-1:0]  rptr_q, rptr_d;
    logic [adrbits:0]    rcnt_q, rcnt_d;
    logic [databits-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic                load_s;
    logic                accept_s;

    assign load_s   = active_i && (!rd_valid_q || rd_ready_i) && (rcnt_q != {(adrbits + 1){1'b0}});
    assign accept_s = rd_valid_q && rd_ready_i;

    // Pointer/count bookkeeping and output register load.
    always_comb begin
        rptr_d     = rptr_q;
        rcnt_d     = rcnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        if (start_i) begin
            rptr_d     = start_addr_i;
            rcnt_d     = len_i;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else if (load_s) begin
            rd_data_d  = q_i;
            rd_valid_d = 1'b1;
            rd_last_d  = (rcnt_q == CNT_ONE);
            rptr_d     = rptr_q + PTR_ONE;
            rcnt_d     = rcnt_q - CNT_ONE;
        end else if (accept_s) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
        end
    end

    // Readout state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q     <= {adrbits{1'b0}};
            rcnt_q     <= {(adrbits + 1){1'b0}};
            rd_data_q  <= {databits{1'b0}};
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            rcnt_q     <= rcnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_last_o     = rd_last_q;
    assign rd_address_o  = rptr_q;
    assign last_accept_o = accept_s && rd_last_q;

endmodule

// File: rtl/trace_ctrl.sv
// Debug trace controller: circular capture into the trace RAM around a trigger,
// then oldest-first readout via trace_rd_stream.
module trace_ctrl
    import trace_ctrl_pkg::*;
#(
    parameter int adrbits  = TRACE_ADRBITS_DEFAULT,
    parameter int databits = TRACE_DATABITS_DEFAULT
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Arm,
    input  logic [adrbits-1:0]  PostCount,
    input  logic [databits-1:0] Sample,
    input  logic                SampleValid,
    input  logic                Trigger,
    input  logic                RdReq,
    output logic                Armed,
    output logic                Triggered,
    output logic                Done,
    trace_ctrl_if.master        bus
);
    localparam int unsigned        DEPTH    = trace_depth(adrbits);
    localparam logic [adrbits:0]   LEN_FULL = (adrbits + 1)'(DEPTH);
    localparam logic [adrbits-1:0] PTR_ONE  = adrbits'(32'd1);

    trace_state_e        state_q, state_d;
    logic [adrbits-1:0]  wptr_q, wptr_d;
    logic                wrapped_q, wrapped_d;
    logic [adrbits-1:0]  pcnt_q, pcnt_d;
    logic                we_q, we_d;
    logic [adrbits-1:0]  wr_address_q, wr_address_d;
    logic [databits-1:0] data_q, data_d;
    logic                armed_q, armed_d;
    logic                triggered_q, triggered_d;
    logic                done_q, done_d;

    logic                sample_take_s;
    logic                arm_take_s;
    logic                rd_start_s;
    logic                rd_last_accept_s;
    logic [adrbits-1:0]  rd_start_addr_s;
    logic [adrbits:0]    rd_len_s;
    logic [databits-1:0] rd_data_s;
    logic                rd_valid_s;
    logic                rd_last_s;
    logic [adrbits-1:0]  rd_address_s;

    assign sample_take_s = SampleValid && ((state_q == ST_ARMED) || (state_q == ST_POST));
    assign arm_take_s    = Arm && (state_q == ST_IDLE);

    // Once wrapped, the oldest word sits at the write pointer and the buffer is full.
    assign rd_start_addr_s = wrapped_q ? wptr_q : {adrbits{1'b0}};
    assign rd_len_s        = wrapped_q ? LEN_FULL : {1'b0, wptr_q};

    // Capture/readout sequencing.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        rd_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Arm) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (SampleValid && Trigger) begin
                    pcnt_d  = PostCount;
                    state_d = (PostCount == {adrbits{1'b0}}) ? ST_DONE : ST_POST;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_POST: begin
                if (SampleValid) begin
                    pcnt_d  = pcnt_q - PTR_ONE;
                    state_d = (pcnt_q == PTR_ONE) ? ST_DONE : ST_POST;
                end else begin
                    state_d = ST_POST;
                end
            end
            ST_DONE: begin
                if (RdReq) begin
                    rd_start_s = 1'b1;
                    state_d    = ST_READ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (rd_last_accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write pointer, wrap flag and the registered RAM write port.
    always_comb begin
        wptr_d       = wptr_q;
        wrapped_d    = wrapped_q;
        we_d         = 1'b0;
        wr_address_d = wr_address_q;
        data_d       = data_q;
        if (arm_take_s) begin
            wptr_d    = {adrbits{1'b0}};
            wrapped_d = 1'b0;
        end else if (sample_take_s) begin
            we_d         = 1'b1;
            wr_address_d = wptr_q;
            data_d       = Sample;
            wptr_d       = wptr_q + PTR_ONE;
            wrapped_d    = wrapped_q | (wptr_q == {adrbits{1'b1}});
        end else begin
            we_d = 1'b0;
        end
    end

    // Status flags follow the next state so they line up with the new state.
    always_comb begin
        armed_d     = (state_d == ST_ARMED) || (state_d == ST_POST);
        triggered_d = (state_d == ST_POST) || (state_d == ST_DONE);
        done_d      = (state_d == ST_DONE);
    end

    // Controller state registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            wptr_q       <= {adrbits{1'b0}};
            wrapped_q    <= 1'b0;
            pcnt_q       <= {adrbits{1'b0}};
            we_q         <= 1'b0;
            wr_address_q <= {adrbits{1'b0}};
            data_q       <= {databits{1'b0}};
            armed_q      <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            wrapped_q    <= wrapped_d;
            pcnt_q       <= pcnt_d;
            we_q         <= we_d;
            wr_address_q <= wr_address_d;
            data_q       <= data_d;
            armed_q      <= armed_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
        end
    end

    trace_rd_stream #(
        .adrbits  (adrbits),
        .databits (databits)
    ) u_rd_stream (
        .clk           (Clock),
        .rst           (Reset),
        .start_i       (rd_start_s),
        .start_addr_i  (rd_start_addr_s),
        .len_i         (rd_len_s),
        .active_i      (state_q == ST_READ),
        .q_i           (bus.Q),
        .rd_ready_i    (bus.RdReady),
        .rd_data_o     (rd_data_s),
        .rd_valid_o    (rd_valid_s),
        .rd_last_o     (rd_last_s),
        .rd_address_o  (rd_address_s),
        .last_accept_o (rd_last_accept_s)
    );

    assign bus.WE        = we_q;
    assign bus.WrAddress = wr_address_q;
    assign bus.Data      = data_q;
    assign bus.RdAddress = rd_address_s;
    assign bus.RdData    = rd_data_s;
    assign bus.RdValid   = rd_valid_s;
    assign bus.RdLast    = rd_last_s;
    assign Armed         = armed_q;
    assign Triggered     = triggered_q;
    assign Done          = done_q;

endmodule

// File: tb/tb_trace_ctrl.sv
// Randomized bench for trace_ctrl with a RAM model and a sample-history reference.
module tb_trace_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Arm;
    logic [AW-1:0] PostCount;
    logic [DW-1:0] Sample;
    logic          SampleValid;
    logic          Trigger;
    logic          RdReq;
    logic          Armed;
    logic          Triggered;
    logic          Done;

    trace_ctrl_if #(.adrbits(AW), .databits(DW)) bus ();

    trace_ctrl #(.adrbits(AW), .databits(DW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Arm         (Arm),
        .PostCount   (PostCount),
        .Sample      (Sample),
        .SampleValid (SampleValid),
        .Trigger     (Trigger),
        .RdReq       (RdReq),
        .Armed       (Armed),
        .Triggered   (Triggered),
        .Done        (Done),
        .bus         (bus)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge Clock) begin
        if (bus.WE) mem[bus.WrAddress] <= bus.Data;
    end
    assign bus.Q = mem[bus.RdAddress];

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] stim_vals[$];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // phase: 1 armed, 2 post-trigger, 3 done -> {Armed, Triggered, Done}
    function automatic logic [2:0] status_of(input int phase);
        case (phase)
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    task automatic do_reset();
        Reset = 1'b1; Arm = 1'b0; SampleValid = 1'b0; Trigger = 1'b0; RdReq = 1'b0;
        Sample = '0; PostCount = '0; bus.RdReady = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        check_eq("rst_we", 32'(bus.WE), 32'd0);
        check_eq("rst_rdvalid", 32'(bus.RdValid), 32'd0);
        check_eq("rst_rdlast", 32'(bus.RdLast), 32'd0);
        check_eq("rst_status", 32'({Armed, Triggered, Done}), 32'd0);
        check_eq("rst_wraddr", 32'(bus.WrAddress), 32'd0);
        check_eq("rst_rdaddr", 32'(bus.RdAddress), 32'd0);
        check_eq("rst_data", 32'(bus.Data), 32'd0);
        check_eq("rst_rddata", 32'(bus.RdData), 32'd0);
    endtask

    // gap_mode: 0 none, 1 random idle cycles, 2 one idle cycle with Arm/Trigger/RdReq asserted
    task automatic capture(input int trig_idx, input int pcount, input int gap_mode);
        int  phase;
        int  remaining;
        bit  wrote;
        hist.delete();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        check_eq("arm_status", 32'({Armed, Triggered, Done}), 32'(3'b100));
        phase = 1;
        remaining = 0;
        for (int i = 0; i < stim_vals.size(); i++) begin
            int g;
            g = (gap_mode == 1) ? int'($urandom_range(0, 2)) : ((gap_mode == 2) ? 1 : 0);
            for (int k = 0; k < g; k++) begin
                SampleValid = 1'b0;
                Trigger = (gap_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                Arm     = (gap_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                RdReq   = (phase != 3) ? ((gap_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                tick();
                Arm = 1'b0; Trigger = 1'b0; RdReq = 1'b0;
                check_eq("gap_we", 32'(bus.WE), 32'd0);
                check_eq("gap_status", 32'({Armed, Triggered, Done}), 32'(status_of(phase)));
            end
            SampleValid = 1'b1;
            Sample      = stim_vals[i];
            Trigger     = (i == trig_idx);
            PostCount   = (i == trig_idx) ? AW'(pcount) : AW'($urandom);
            tick();
            SampleValid = 1'b0;
            Trigger     = 1'b0;
            wrote = (phase == 1) || (phase == 2);
            if (wrote) hist.push_back(stim_vals[i]);
            if (phase == 1 && i == trig_idx) begin
                remaining = pcount;
                phase = (pcount == 0) ? 3 : 2;
            end else if (phase == 2) begin
                remaining--;
                if (remaining == 0) phase = 3;
            end
            check_eq("we", 32'(bus.WE), 32'(wrote));
            if (wrote) begin
                check_eq("wr_addr", 32'(bus.WrAddress), 32'((hist.size() - 1) % DEPTH));
                check_eq("wr_data", 32'(bus.Data), 32'(stim_vals[i]));
            end
            check_eq("status", 32'({Armed, Triggered, Done}), 32'(status_of(phase)));
        end
        check_eq("done_at_end", 32'(Done), 32'd1);
        exp_q.delete();
        for (int i = (hist.size() > DEPTH) ? hist.size() - DEPTH : 0; i < hist.size(); i++)
            exp_q.push_back(hist[i]);
    endtask

    // mode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random; abort_after>=0 resets after that many words
    task automatic readout(input int mode, input int abort_after);
        int            idx = 0;
        int            cyc = 0;
        int            len = exp_q.size();
        bit            stalled = 1'b0;
        bit            held_last = 1'b0;
        bit            fin = 1'b0;
        bit            rdy;
        logic [DW-1:0] held_data = '0;
        bus.RdReady = 1'b0;
        RdReq = 1'b1;
        tick();
        RdReq = 1'b0;
        check_eq("rd_latency1", 32'(bus.RdValid), 32'd0);
        tick();
        check_eq("rd_latency2", 32'(bus.RdValid), 32'd1);
        while (!fin && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.RdReady = rdy;
            if (stalled) begin
                check_eq("hold_valid", 32'(bus.RdValid), 32'd1);
                check_eq("hold_data", 32'(bus.RdData), 32'(held_data));
                check_eq("hold_last", 32'(bus.RdLast), 32'(held_last));
            end
            if (mode == 0) check_eq("no_bubble", 32'(bus.RdValid), 32'd1);
            stalled = 1'b0;
            if (bus.RdValid) begin
                if (rdy) begin
                    if (idx < len) begin
                        check_eq("rd_data", 32'(bus.RdData), 32'(exp_q[idx]));
                        check_eq("rd_last", 32'(bus.RdLast), 32'(idx == len - 1));
                    end else begin
                        check_eq("rd_extra", 32'(idx), 32'(len - 1));
                        fin = 1'b1;
                    end
                    idx++;
                    if (bus.RdLast) fin = 1'b1;
                end else begin
                    stalled   = 1'b1;
                    held_data = bus.RdData;
                    held_last = bus.RdLast;
                end
            end
            if (abort_after >= 0 && idx == abort_after) begin
                Reset = 1'b1;
                tick();
                Reset = 1'b0;
                bus.RdReady = 1'b0;
                check_eq("abort_valid", 32'(bus.RdValid), 32'd0);
                check_eq("abort_we", 32'(bus.WE), 32'd0);
                check_eq("abort_status", 32'({Armed, Triggered, Done}), 32'd0);
                return;
            end
            tick();
            cyc++;
        end
        bus.RdReady = 1'b0;
        check_eq("rd_finished", 32'(fin), 32'd1);
        check_eq("rd_count", 32'(idx), 32'(len));
        check_eq("post_rd_valid", 32'(bus.RdValid), 32'd0);
        check_eq("post_rd_status", 32'({Armed, Triggered, Done}), 32'd0);
        RdReq = 1'b1;
        tick();
        RdReq = 1'b0;
        tick();
        check_eq("rdreq_idle", 32'(bus.RdValid), 32'd0);
    endtask

    task automatic load_counting(input int first, input int n);
        stim_vals.delete();
        for (int i = 0; i < n; i++) stim_vals.push_back(DW'(first + i));
    endtask

    task automatic load_random(input int n);
        stim_vals.delete();
        for (int i = 0; i < n; i++) stim_vals.push_back(DW'($urandom));
    endtask

    initial begin
        do_reset();

        load_counting(0, 6);
        capture(3, 2, 0);
        readout(0, -1);

        load_counting(0, 40);
        capture(30, 5, 0);
        readout(0, -1);

        stim_vals.delete();
        stim_vals.push_back(16'hAAAA);
        stim_vals.push_back(16'h1111);
        stim_vals.push_back(16'h2222);
        capture(0, 0, 0);
        readout(0, -1);

        load_random(12);
        capture(8, 3, 0);
        readout(1, -1);

        load_counting(100, 10);
        capture(4, 4, 2);
        readout(2, -1);

        load_counting(200, 18);
        capture(10, 5, 0);
        readout(0, -1);

        load_random(10);
        capture(5, 3, 1);
        readout(0, 3);
        load_random(6);
        capture(2, 2, 0);
        readout(2, -1);

        for (int t = 0; t < 4; t++) begin
            int trig;
            int pc;
            trig = int'($urandom_range(0, 25));
            pc   = int'($urandom_range(0, 15));
            load_random(trig + pc + 1 + int'($urandom_range(0, 3)));
            capture(trig, pc, 1);
            readout(2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trace_ctrl.md
# trace_ctrl

Capture-and-readout controller for the debug trace RAM (simple dual-port, async read, `adrbits`×`databits`). It is armed by the host, writes qualified samples into the RAM as a circular buffer, stops a programmable number of samples after a trigger, then streams the buffer out oldest-first over a valid/ready port. It owns both RAM ports; nothing else writes the RAM.

## Interface
- `adrbits`, 12: RAM address width; depth is 2^adrbits.
- `databits`, 16: sample and RAM word width.

- `Clock`  in  1  single clock. It also drives the RAM `WrClock`/`RdClock`.
- `Reset`  in  1  synchronous, active-high.
- `Arm`  in  1  pulse; starts a capture. Honoured only in IDLE.
- `PostCount`  in  adrbits  number of samples to store after the trigger sample. Sampled when the trigger is accepted.
- `Sample`  in  databits  probe data.
- `SampleValid`  in  1  qualifies `Sample` this cycle.
- `Trigger`  in  1  trigger condition. Only meaningful when `SampleValid` is high.
- `RdReq`  in  1  pulse; starts readout. Honoured only in DONE.
- `RdReady`  in  1  consumer accepts `RdData` this cycle.
- `RdData`  out  databits  readout word.
- `RdValid`  out  1  `RdData` valid.
- `RdLast`  out  1  marks the final word of the readout.
- `Armed`, `Triggered`, `Done`  out  1 each  status: state ∈ {ARMED, POST}; state ∈ {POST, DONE}; state = DONE.
- `WrAddress`  out  adrbits  to RAM.
- `Data`  out  databits  to RAM.
- `WE`  out  1  to RAM. `WrClockEn` is tied 1 externally.
- `RdAddress`  out  adrbits  to RAM.
- `Q`  in  databits  from RAM. Combinational read of `RdAddress`.

## Operation
- States: IDLE, ARMED, POST, DONE, READ. Reset forces IDLE.
- IDLE + `Arm`:
  - Clear `wptr` (adrbits) and `Wrapped`.
  - Go to ARMED.
- ARMED, on each `SampleValid`:
  - Write `Sample` at `wptr`, then `wptr`+1 modulo 2^adrbits.
  - Set `Wrapped` when `wptr` goes from 2^adrbits−1 to 0.
- ARMED, on `SampleValid && Trigger`:
  - The trigger sample is written as a normal sample.
  - Load `pcnt` ← `PostCount`.
  - Go to POST, or directly to DONE if `PostCount`=0.
- POST, on each `SampleValid`:
  - Write the sample and decrement `pcnt`.
  - The write that takes `pcnt` from 1 to 0 is the last one; go to DONE on that write.
- DONE: buffer is frozen.
  - start = `Wrapped` ? `wptr` : 0.
  - len = `Wrapped` ? 2^adrbits : `wptr`. len is adrbits+1 bits wide.
- DONE + `RdReq`:
  - `rptr` ← start, `rcnt` ← len.
  - Go to READ.
- READ:
  - Output register loads `Q` when (`!RdValid || RdReady`) and `rcnt`≠0.
  - On each load, `rptr` increments (wraps) and `rcnt` decrements.
  - `RdLast` is set with the load where `rcnt`=1.
  - When a word with `RdLast` is accepted (`RdValid && RdReady`), go to IDLE.
- Ignored inputs:
  - `Arm` outside IDLE; abort is by `Reset` only.
  - `RdReq` outside DONE.
  - `Trigger` without `SampleValid`.
  - `SampleValid` in IDLE, DONE and READ.
- Wrap-around:
  - More than 2^adrbits samples before the trigger overwrites the oldest.
  - If `PostCount` ≥ 2^adrbits the trigger sample itself can be overwritten. This is legal and not flagged.
- Reset mid-operation:
  - Next state is IDLE; `WE`=0 and `RdValid`=0 from the cycle after `Reset`.
  - RAM contents are untouched.

## Timing
- Reset values:
  - `WE`, `RdValid`, `RdLast`, `Armed`, `Triggered`, `Done` = 0.
  - `WrAddress`, `RdAddress`, `Data`, `RdData` = 0.
- Write path is registered. A `SampleValid` at cycle n drives `WE`=1, `WrAddress`=`wptr`, `Data`=`Sample` in cycle n+1, and the RAM stores the word at the end of n+1.
  - Back-to-back samples give one write per cycle.
- `RdAddress` = `rptr` (registered). `Q` is sampled combinationally.
  - First `RdValid` comes 2 cycles after `RdReq`.
  - Holding `RdReady`=1 then yields one word per cycle with no bubbles.
- Backpressure: while `RdValid && !RdReady`, `RdData`, `RdLast` and `rptr` hold.
- Status outputs are registered and change one cycle after the state transition.
- No RAM read/write collision: writes never occur in READ.

## Structure
- Shared package holds:
  - State encoding enum: IDLE=0, ARMED=1, POST=2, DONE=3, READ=4.
  - Depth constant 2^adrbits.
- One sub-module is natural: `trace_rd_stream`. It contains `rptr`, `rcnt`, the output register and valid/ready/last.
- Sequencing, `wptr`/`Wrapped`/`pcnt` and the write path stay in `trace_ctrl`.

## Test plan
All tests use adrbits=4 (depth 16), databits=16.
- Basic capture:
  - Stimulus: Arm; samples 0..5 with Trigger on sample 3; PostCount=2.
  - Response: Done after sample 5; readout 0,1,2,3,4,5 with RdLast on 5; then IDLE.
- Wrap:
  - Stimulus: Arm; samples 0..39, Trigger on 30, PostCount=5.
  - Response: readout 16 words, 20..35, RdLast on 35.
- PostCount=0:
  - Stimulus: Trigger on first sample (value 0xAAAA).
  - Response: Done next cycle; readout is the single word 0xAAAA with RdLast.
- Backpressure:
  - Stimulus: RdReady toggled 1,0,0,1,…
  - Response: RdData stable while stalled; sequence unchanged; no word lost or duplicated.
- Ignored inputs:
  - Stimulus: Trigger without SampleValid; Arm during POST; RdReq during ARMED.
  - Response: no state change; no writes from the ignored inputs.
- Reset mid-READ:
  - Stimulus: Reset after 3 words.
  - Response: RdValid=0, state IDLE next cycle; a new Arm/capture works normally.
